matvec_row_accumulator: RTL and testbench

- Datapath stage directly downstream of the element index counter. Consumes its element_index, new_row and new_vector outputs.
- Computes y = W·x for a 3x3 signed weight matrix. Weights arrive one per cycle in row-major order; the input vector x is 3 elements wide.
- Produces a registered 3-element result vector and a one-cycle valid pulse per completed vector. The result feeds the activation/output stage of the network.

---
 rtl/matvec_row_accumulator.sv | 212 +++++++++++++++++++++
 tb/tb_matvec_row_accumulator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/matvec_row_accumulator.sv
// -----------------------------------------------------------------------------
// matvec_row_accumulator
//
// Computes y = W * x for a 3x3 signed weight matrix. Weights stream in one per
// cycle in row-major order, tagged by the element index counter upstream.
// Each row's dot product is built in a single accumulator. Finished rows are
// parked in work registers. At the end of the vector, all three sums are
// published together on y_vec, with a one-cycle out_valid pulse.
//
// Optional build macro:
//   MATVEC_RELU_EN - when defined, each lane written to y_vec is clamped to
//                    max(0, value). The work registers always keep raw sums.
//
// Ports:
//   clock          in   system clock, rising edge
//   clear          in   asynchronous active-high reset
//   en             in   sample enable
//   element_index  in   [3:0] weight position 0..8 (row-major)
//   new_row        in   strobe: last element of row 0 or row 1
//   new_vector     in   strobe: last element of row 2
//   weight         in   [DATA_W-1:0] signed weight W[row][col]
//   x_vec          in   [3*DATA_W-1:0] {x2,x1,x0}, sampled at index 0 only
//   y_vec          out  [3*ACC_W-1:0] {y2,y1,y0}, last completed result
//   out_valid      out  one-cycle pulse when y_vec updates
//   index_error    out  sticky: index > 8 seen while en was high
// -----------------------------------------------------------------------------
module matvec_row_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+2
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      en,
  input  logic [3:0]                element_index,
  input  logic                      new_row,
  input  logic                      new_vector,
  input  logic signed [DATA_W-1:0]  weight,
  input  logic [3*DATA_W-1:0]       x_vec,
  output logic [3*ACC_W-1:0]        y_vec,
  output logic                      out_valid,
  output logic                      index_error
);

  localparam int PROD_W = 2*DATA_W;

  // ---------------------------------------------------------------------------
  // Index decode: row = index div 3, col = index mod 3, by direct compare
  // ---------------------------------------------------------------------------
  logic [1:0] col;
  logic [1:0] row;
  logic       idx_ok;

  always_comb begin
    col = 2'd0;
    row = 2'd0;
    case (element_index)
      4'd0: begin col = 2'd0; row = 2'd0; end
      4'd1: begin col = 2'd1; row = 2'd0; end
      4'd2: begin col = 2'd2; row = 2'd0; end
      4'd3: begin col = 2'd0; row = 2'd1; end
      4'd4: begin col = 2'd1; row = 2'd1; end
      4'd5: begin col = 2'd2; row = 2'd1; end
      4'd6: begin col = 2'd0; row = 2'd2; end
      4'd7: begin col = 2'd1; row = 2'd2; end
      4'd8: begin col = 2'd2; row = 2'd2; end
      default: begin col = 2'd0; row = 2'd0; end
    endcase
  end

  assign idx_ok = (element_index <= 4'd8);

  logic sample;
  logic row_end;
  logic vec_end;

  assign sample  = en && idx_ok;
  assign row_end = sample && (new_row || new_vector);
  assign vec_end = sample && new_vector;

  // ---------------------------------------------------------------------------
  // x latch: all three elements are captured at index 0.
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] x_in    [3];
  logic signed [DATA_W-1:0] x_lat_q [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_xlat
      assign x_in[gi] = x_vec[gi*DATA_W +: DATA_W];

      always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
          x_lat_q[gi] <= '0;
        end else if (sample && (element_index == 4'd0)) begin
          x_lat_q[gi] <= x_in[gi];
        end
      end
    end
  endgenerate

  // Index 0 bypasses the latch so that the first product is not a cycle late.
  logic signed [DATA_W-1:0] x_sel;

  always_comb begin
    if (element_index == 4'd0) begin
      x_sel = x_in[0];
    end else begin
      x_sel = x_lat_q[col];
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply-accumulate. col==0 restarts the row, so back-to-back vectors
  // need no bubble between index 8 and the next index 0.
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  always_comb begin
    prod     = weight * x_sel;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_d    = ((col == 2'd0) ? '0 : acc_q) + prod_ext;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc_q <= '0;
    end else if (sample) begin
      acc_q <= acc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Work rows. A row-end strobe controls the write timing, even when it
  // arrives at an unexpected index.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] work_q [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_work
      always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
          work_q[gi] <= '0;
        end else if (row_end && (row == 2'(gi))) begin
          work_q[gi] <= acc_d;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Result register. Lane 2 comes straight from acc_d, because row 2 completes
  // in the same cycle that the vector ends.
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] y_src [3];
  logic signed [ACC_W-1:0] y_d   [3];
  logic signed [ACC_W-1:0] y_q   [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_y
      if (gi == 2) begin : g_last
        assign y_src[gi] = acc_d;
      end else begin : g_work_src
        assign y_src[gi] = work_q[gi];
      end

`ifdef MATVEC_RELU_EN
      assign y_d[gi] = y_src[gi][ACC_W-1] ? '0 : y_src[gi];
`else
      assign y_d[gi] = y_src[gi];
`endif

      always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
          y_q[gi] <= '0;
        end else if (vec_end) begin
          y_q[gi] <= y_d[gi];
        end
      end

      assign y_vec[gi*ACC_W +: ACC_W] = y_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Valid pulse and sticky index error flag
  // ---------------------------------------------------------------------------
  logic valid_q;
  logic valid_d;
  logic err_q;
  logic err_d;

  always_comb begin
    valid_d = vec_end;
    err_d   = err_q || (en && !idx_ok);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_valid   = valid_q;
  assign index_error = err_q;

endmodule

// File: tb/tb_matvec_row_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench for matvec_row_accumulator.
// Directed vectors with hand-computed results.
// -----------------------------------------------------------------------------
module tb_matvec_row_accumulator;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;

  logic                      clock;
  logic                      clear;
  logic                      en;
  logic [3:0]                element_index;
  logic                      new_row;
  logic                      new_vector;
  logic signed [DATA_W-1:0]  weight;
  logic [3*DATA_W-1:0]       x_vec;
  logic [3*ACC_W-1:0]        y_vec;
  logic                      out_valid;
  logic                      index_error;

  matvec_row_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clock         (clock),
    .clear         (clear),
    .en            (en),
    .element_index (element_index),
    .new_row       (new_row),
    .new_vector    (new_vector),
    .weight        (weight),
    .x_vec         (x_vec),
    .y_vec         (y_vec),
    .out_valid     (out_valid),
    .index_error   (index_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  logic signed [DATA_W-1:0] w_cur [9];
  logic signed [DATA_W-1:0] x_cur [3];

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [63:0] pack_y(input int y0, input int y1, input int y2);
    logic [ACC_W-1:0] a, b, c;
    a = y0[ACC_W-1:0];
    b = y1[ACC_W-1:0];
    c = y2[ACC_W-1:0];
    return 64'({c, b, a});
  endfunction

  function automatic int relu(input int v);
`ifdef MATVEC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Drive one cycle at the falling edge, then settle just after the rising edge.
  // x_vec carries the real vector only at index 0, which exercises the latch.
  task automatic tick(input int idx, input logic e);
    @(negedge clock);
    element_index = idx[3:0];
    weight        = (idx < 9) ? w_cur[idx] : 8'sd0;
    new_row       = (idx == 2) || (idx == 5);
    new_vector    = (idx == 8);
    en            = e;
    x_vec         = (idx == 0) ? {x_cur[2], x_cur[1], x_cur[0]} : 24'h5AA55A;
    @(posedge clock);
    #1;
    if (out_valid) pulses++;
  endtask

  task automatic run_vector();
    for (int i = 0; i < 9; i++) tick(i, 1'b1);
  endtask

  task automatic set_w_123();
    for (int i = 0; i < 9; i++) w_cur[i] = 8'(i + 1);
  endtask

  task automatic set_x(input int a, input int b, input int c);
    x_cur[0] = 8'(a);
    x_cur[1] = 8'(b);
    x_cur[2] = 8'(c);
  endtask

  initial begin
    clear = 1'b1; en = 1'b0; element_index = '0; new_row = 1'b0;
    new_vector = 1'b0; weight = '0; x_vec = '0;
    #1;
    check_value("reset_y", 64'(y_vec), 64'd0);
    check_value("reset_valid", 64'(out_valid), 64'd0);
    check_value("reset_err", 64'(index_error), 64'd0);
    @(negedge clock); @(negedge clock);
    clear = 1'b0;

    // Test 1: W = 1..9, x = [1,1,1]
    set_w_123(); set_x(1, 1, 1); pulses = 0;
    run_vector();
    check_value("t1_valid", 64'(out_valid), 64'd1);
    check_value("t1_y", 64'(y_vec), pack_y(6, 15, 24));
    tick(0, 1'b0);
    check_value("t1_valid_drop", 64'(out_valid), 64'd0);
    check_value("t1_y_hold", 64'(y_vec), pack_y(6, 15, 24));
    check_value("t1_pulses", 64'(pulses), 64'd1);

    // Test 2: all -128, with no wrap in 18 bits
    for (int i = 0; i < 9; i++) w_cur[i] = -8'sd128;
    set_x(-128, -128, -128);
    run_vector();
    check_value("t2_valid", 64'(out_valid), 64'd1);
    check_value("t2_y", 64'(y_vec), pack_y(49152, 49152, 49152));

    // Test 3: back-to-back vectors with no bubble
    set_w_123(); set_x(1, 0, 0); pulses = 0;
    run_vector();
    check_value("t3a_valid", 64'(out_valid), 64'd1);
    check_value("t3a_y", 64'(y_vec), pack_y(1, 4, 7));
    set_x(0, 0, 1);
    for (int i = 0; i < 8; i++) tick(i, 1'b1);
    check_value("t3_y_held", 64'(y_vec), pack_y(1, 4, 7));
    check_value("t3_no_pulse_mid", 64'(pulses), 64'd1);
    tick(8, 1'b1);
    check_value("t3b_valid", 64'(out_valid), 64'd1);
    check_value("t3b_y", 64'(y_vec), pack_y(3, 6, 9));
    tick(0, 1'b0);
    check_value("t3_pulses", 64'(pulses), 64'd2);

    // Test 4: en low for 5 cycles at index 4
    set_x(1, 1, 1); pulses = 0;
    for (int i = 0; i < 4; i++) tick(i, 1'b1);
    for (int k = 0; k < 5; k++) tick(4, 1'b0);
    for (int i = 4; i < 9; i++) tick(i, 1'b1);
    check_value("t4_valid", 64'(out_valid), 64'd1);
    check_value("t4_y", 64'(y_vec), pack_y(6, 15, 24));
    tick(0, 1'b0);
    check_value("t4_pulses", 64'(pulses), 64'd1);

    // Test 6: W = -1, x = [1,2,3]; then an out-of-range index
    for (int i = 0; i < 9; i++) w_cur[i] = -8'sd1;
    set_x(1, 2, 3);
    run_vector();
    check_value("t6_valid", 64'(out_valid), 64'd1);
    check_value("t6_y", 64'(y_vec), pack_y(relu(-6), relu(-6), relu(-6)));
    check_value("t6_err_before", 64'(index_error), 64'd0);
    tick(12, 1'b1);
    check_value("t6_err_set", 64'(index_error), 64'd1);
    check_value("t6_y_unchanged", 64'(y_vec), pack_y(relu(-6), relu(-6), relu(-6)));
    tick(0, 1'b0);
    check_value("t6_err_sticky", 64'(index_error), 64'd1);

    // Test 5: clear at index 5 aborts the vector
    set_w_123(); set_x(1, 1, 1); pulses = 0;
    for (int i = 0; i < 5; i++) tick(i, 1'b1);
    @(negedge clock);
    element_index = 4'd5; weight = w_cur[5]; new_row = 1'b1; en = 1'b1;
    clear = 1'b1;
    #1;
    check_value("t5_clr_y", 64'(y_vec), 64'd0);
    check_value("t5_clr_valid", 64'(out_valid), 64'd0);
    check_value("t5_clr_err", 64'(index_error), 64'd0);
    @(negedge clock);
    clear = 1'b0; en = 1'b0;
    tick(0, 1'b0);
    check_value("t5_no_abort_pulse", 64'(pulses), 64'd0);
    run_vector();
    check_value("t5_valid", 64'(out_valid), 64'd1);
    check_value("t5_y", 64'(y_vec), pack_y(6, 15, 24));
    tick(0, 1'b0);
    check_value("t5_pulses", 64'(pulses), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
